snd_mailbox_ctrl: RTL and testbench

Sequences the 68k↔6502 sound mailbox. It queues 68k command bytes in a small FIFO for the sound CPU and generates paced NMI pulses to the 6502 while commands are pending. It holds the single-byte 6502→68k response latch and drives SNDINT_b to the 68k. It sits between the 68k bus decode and io_sound, replacing the bare single-latch handoff with a scheduled, overflow-tracked channel.

---
 rtl/snd_mbox_pkg.sv | 26 ++
 rtl/snd_mailbox_ctrl_if.sv | 42 ++++
 rtl/snd_cmd_fifo.sv | 81 ++++++++
 rtl/snd_mailbox_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_snd_mailbox_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snd_mbox_pkg.sv
// -----------------------------------------------------------------------------
// snd_mbox_pkg
// Shared types and default parameters for the 68k <-> 6502 sound mailbox.
//   nmi_state_t : states of the NMI pacing FSM
//   DEF_*       : default FIFO depth and NMI pulse/gap lengths (clk100 cycles)
//   maxOf       : helper used to size the shared NMI down-counter
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package snd_mbox_pkg;

    localparam int DEF_DEPTH   = 4;
    localparam int DEF_NMI_LEN = 16;
    localparam int DEF_NMI_GAP = 8;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        WAIT_ACK,
        GAP
    } nmi_state_t;

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/snd_mailbox_ctrl_if.sv
// -----------------------------------------------------------------------------
// snd_mailbox_ctrl_if
// Bus-side signals of the sound mailbox, grouped for both CPUs.
//   68k side  : SNDWR_b, SNDRD_b, Dout68k (to mailbox), Din68k, SNDINT_b
//   6502 side : WR68k_b, RD68k_b, Dout6502 (to mailbox), Din6502, SNDNMI_b
//   status    : ctrl_68kBUF, ctrl_SNDBUF, cmd_count, cmd_ovf, resp_ovf
// master = bus decode / CPUs driving strobes, slave = the mailbox controller.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface snd_mailbox_ctrl_if
    import snd_mbox_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
);
    logic                       SNDWR_b;
    logic                       SNDRD_b;
    logic [7:0]                 Dout68k;
    logic [7:0]                 Din68k;
    logic                       WR68k_b;
    logic                       RD68k_b;
    logic [7:0]                 Dout6502;
    logic [7:0]                 Din6502;
    logic                       SNDNMI_b;
    logic                       SNDINT_b;
    logic                       ctrl_68kBUF;
    logic                       ctrl_SNDBUF;
    logic [$clog2(DEPTH+1)-1:0] cmd_count;
    logic                       cmd_ovf;
    logic                       resp_ovf;

    modport master (
        output SNDWR_b, SNDRD_b, Dout68k, WR68k_b, RD68k_b, Dout6502,
        input  Din68k, Din6502, SNDNMI_b, SNDINT_b,
               ctrl_68kBUF, ctrl_SNDBUF, cmd_count, cmd_ovf, resp_ovf
    );

    modport slave (
        input  SNDWR_b, SNDRD_b, Dout68k, WR68k_b, RD68k_b, Dout6502,
        output Din68k, Din6502, SNDNMI_b, SNDINT_b,
               ctrl_68kBUF, ctrl_SNDBUF, cmd_count, cmd_ovf, resp_ovf
    );
endinterface

// File: rtl/snd_cmd_fifo.sv
// -----------------------------------------------------------------------------
// snd_cmd_fifo
// Synchronous command FIFO with synchronous flush.
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_flush        : synchronous empty, overrides push/pop
//   i_push, i_data : write request and byte
//   i_pop          : read request (ignored when empty)
//   o_head         : byte at the read pointer (only meaningful when not empty)
//   o_count        : occupancy 0..DEPTH
//   o_full/o_empty : occupancy flags
//   o_popDone      : a pop was actually performed this cycle
// A push into a full FIFO is accepted only when a pop frees a slot in the
// same cycle; otherwise it is silently dropped.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module snd_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_popDone
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rdPtr;
    logic [PW-1:0]    r_wrPtr;
    logic [CW-1:0]    r_count;
    logic             w_pushOk;
    logic             w_popOk;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_popOk   = i_pop & ~o_empty;
    assign w_pushOk  = i_push & (~o_full | w_popOk);
    assign o_popDone = w_popOk;
    assign o_head    = r_mem[r_rdPtr];
    assign o_count   = r_count;

    // Storage needs no reset: the head is masked by o_empty upstream.
    always_ff @(posedge clk) begin
        if (w_pushOk && !i_flush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_pushOk) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_popOk) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_pushOk, w_popOk})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/snd_mailbox_ctrl.sv
// -----------------------------------------------------------------------------
// snd_mailbox_ctrl
// 68k <-> 6502 sound mailbox: queues 68k commands, paces NMIs to the 6502 (one
// per pending command, each acknowledged by a 6502 read) and holds the
// single-byte 6502 -> 68k response latch that drives SNDINT_b.
//   clk100   : system clock
//   rst_b    : asynchronous active-low reset
//   SNDRST_b : synchronous active-low sound-side flush
//   bus      : strobes, data and status (see snd_mailbox_ctrl_if)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module snd_mailbox_ctrl
    import snd_mbox_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int NMI_LEN = DEF_NMI_LEN,
    parameter int NMI_GAP = DEF_NMI_GAP
) (
    input  logic               clk100,
    input  logic               rst_b,
    input  logic               SNDRST_b,
    snd_mailbox_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(maxOf(NMI_LEN, NMI_GAP) + 1);

    logic                       r_sndWrPrev;
    logic                       r_sndRdPrev;
    logic                       r_wr68kPrev;
    logic                       r_rd68kPrev;
    logic                       w_flush;
    logic                       w_cmdPush;
    logic                       w_cmdPop;
    logic                       w_respWrite;
    logic                       w_respRead;
    logic [7:0]                 w_fifoHead;
    logic [$clog2(DEPTH+1)-1:0] w_fifoCount;
    logic                       w_fifoFull;
    logic                       w_fifoEmpty;
    logic                       w_popDone;
    logic                       r_cmdOvf;
    logic [7:0]                 r_resp;
    logic                       r_respFull;
    logic                       r_respOvf;
    nmi_state_t                 r_state;
    nmi_state_t                 w_nextState;
    logic [CNT_W-1:0]           r_nmiCnt;
    logic [CNT_W-1:0]           w_nextCnt;
    logic                       w_nmiLow;

    assign w_flush = ~SNDRST_b;

    // Command strobes act on the falling edge; the 6502 command read pops on
    // the rising edge so Din6502 stays stable for the whole read cycle.
    assign w_cmdPush   =  r_sndWrPrev & ~bus.SNDWR_b;
    assign w_cmdPop    = ~r_rd68kPrev &  bus.RD68k_b;
    assign w_respWrite =  r_wr68kPrev & ~bus.WR68k_b;
    assign w_respRead  = ~r_sndRdPrev &  bus.SNDRD_b;

    always_ff @(posedge clk100 or negedge rst_b) begin
        if (!rst_b) begin
            r_sndWrPrev <= 1'b1;
            r_sndRdPrev <= 1'b1;
            r_wr68kPrev <= 1'b1;
            r_rd68kPrev <= 1'b1;
        end else if (w_flush) begin
            r_sndWrPrev <= 1'b1;
            r_sndRdPrev <= 1'b1;
            r_wr68kPrev <= 1'b1;
            r_rd68kPrev <= 1'b1;
        end else begin
            r_sndWrPrev <= bus.SNDWR_b;
            r_sndRdPrev <= bus.SNDRD_b;
            r_wr68kPrev <= bus.WR68k_b;
            r_rd68kPrev <= bus.RD68k_b;
        end
    end

    snd_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk100),
        .rst_n     (rst_b),
        .i_flush   (w_flush),
        .i_push    (w_cmdPush),
        .i_pop     (w_cmdPop),
        .i_data    (bus.Dout68k),
        .o_head    (w_fifoHead),
        .o_count   (w_fifoCount),
        .o_full    (w_fifoFull),
        .o_empty   (w_fifoEmpty),
        .o_popDone (w_popDone)
    );

    // A push onto a full FIFO is only lost when no pop makes room alongside it.
    always_ff @(posedge clk100 or negedge rst_b) begin
        if (!rst_b) begin
            r_cmdOvf <= 1'b0;
        end else if (w_flush) begin
            r_cmdOvf <= 1'b0;
        end else if (w_cmdPush && w_fifoFull && !w_popDone) begin
            r_cmdOvf <= 1'b1;
        end
    end

    // Response latch: a write in the same cycle as a 68k read wins, so the
    // fresh byte is never lost to the read that was finishing.
    always_ff @(posedge clk100 or negedge rst_b) begin
        if (!rst_b) begin
            r_resp     <= 8'h00;
            r_respFull <= 1'b0;
            r_respOvf  <= 1'b0;
        end else if (w_flush) begin
            r_resp     <= 8'h00;
            r_respFull <= 1'b0;
            r_respOvf  <= 1'b0;
        end else if (w_respWrite) begin
            r_resp     <= bus.Dout6502;
            r_respFull <= 1'b1;
            if (r_respFull) begin
                r_respOvf <= 1'b1;
            end
        end else if (w_respRead) begin
            r_respFull <= 1'b0;
        end
    end

    // NMI FSM state register; one down-counter serves both pulse and gap.
    always_ff @(posedge clk100 or negedge rst_b) begin
        if (!rst_b) begin
            r_state  <= IDLE;
            r_nmiCnt <= '0;
        end else if (w_flush) begin
            r_state  <= IDLE;
            r_nmiCnt <= '0;
        end else begin
            r_state  <= w_nextState;
            r_nmiCnt <= w_nextCnt;
        end
    end

    // Next-state logic. A pop during PULSE is not remembered: the FSM still
    // waits for a further pop in WAIT_ACK before opening the gap.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_nmiCnt;
        case (r_state)
            IDLE: begin
                if (w_fifoCount != '0) begin
                    w_nextState = PULSE;
                    w_nextCnt   = CNT_W'(NMI_LEN - 1);
                end
            end
            PULSE: begin
                if (r_nmiCnt == '0) begin
                    w_nextState = WAIT_ACK;
                end else begin
                    w_nextCnt = r_nmiCnt - 1'b1;
                end
            end
            WAIT_ACK: begin
                if (w_popDone) begin
                    w_nextState = GAP;
                    w_nextCnt   = CNT_W'(NMI_GAP - 1);
                end
            end
            GAP: begin
                if (r_nmiCnt == '0) begin
                    w_nextState = IDLE;
                end else begin
                    w_nextCnt = r_nmiCnt - 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_comb begin
        w_nmiLow = 1'b0;
        if (r_state == PULSE) begin
            w_nmiLow = 1'b1;
        end
    end

    assign bus.SNDNMI_b    = ~w_nmiLow;
    assign bus.SNDINT_b    = ~r_respFull;
    assign bus.Din68k      = r_resp;
    assign bus.Din6502     = w_fifoEmpty ? 8'h00 : w_fifoHead;
    assign bus.ctrl_68kBUF = ~w_fifoEmpty;
    assign bus.ctrl_SNDBUF = r_respFull;
    assign bus.cmd_count   = w_fifoCount;
    assign bus.cmd_ovf     = r_cmdOvf;
    assign bus.resp_ovf    = r_respOvf;
endmodule

// File: tb/tb_snd_mailbox_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snd_mailbox_ctrl
// Self-checking bench for snd_mailbox_ctrl: a table of single-cycle vectors,
// hand-written multi-cycle sequences (NMI pacing, same-cycle events, flush,
// async reset) and a randomized phase compared against a queue-based model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_snd_mailbox_ctrl;
    import snd_mbox_pkg::*;

    localparam int DEPTH   = 4;
    localparam int NMI_LEN = 16;
    localparam int NMI_GAP = 8;

    logic clk100 = 1'b0;
    logic rst_b;
    logic SNDRST_b;

    snd_mailbox_ctrl_if #(.DEPTH(DEPTH)) bus ();

    snd_mailbox_ctrl #(
        .DEPTH   (DEPTH),
        .NMI_LEN (NMI_LEN),
        .NMI_GAP (NMI_GAP)
    ) dut (
        .clk100   (clk100),
        .rst_b    (rst_b),
        .SNDRST_b (SNDRST_b),
        .bus      (bus)
    );

    always #5 clk100 = ~clk100;

    int testsRun  = 0;
    int failCount = 0;

    typedef struct {
        logic       sndWr;
        logic       sndRd;
        logic       wr68k;
        logic       rd68k;
        logic [7:0] d68;
        logic [7:0] d65;
        int         expCount;
        logic [7:0] expHead;
        logic [7:0] expResp;
        logic       expRespFull;
        logic       expCmdOvf;
        logic       expRespOvf;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model: the FIFO is a plain queue, the latch a byte + flags.
    logic [7:0] mq[$];
    logic       mCmdOvf;
    logic       mRespFull;
    logic       mRespOvf;
    logic [7:0] mResp;
    logic       pWr, pRd, pW68, pR68;

    task automatic modelReset();
        mq.delete();
        mCmdOvf   = 1'b0;
        mRespFull = 1'b0;
        mRespOvf  = 1'b0;
        mResp     = 8'h00;
        pWr = 1'b1; pRd = 1'b1; pW68 = 1'b1; pR68 = 1'b1;
    endtask

    task automatic modelEdge();
        logic push, pop, wfall, rrise;
        if (!rst_b || !SNDRST_b) begin
            modelReset();
        end else begin
            push  =  pWr  && !bus.SNDWR_b;
            pop   = !pR68 &&  bus.RD68k_b;
            wfall =  pW68 && !bus.WR68k_b;
            rrise = !pRd  &&  bus.SNDRD_b;
            if (pop && mq.size() > 0) void'(mq.pop_front());
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back(bus.Dout68k);
                else                   mCmdOvf = 1'b1;
            end
            if (wfall) begin
                if (mRespFull) mRespOvf = 1'b1;
                mResp     = bus.Dout6502;
                mRespFull = 1'b1;
            end else if (rrise) begin
                mRespFull = 1'b0;
            end
            pWr = bus.SNDWR_b; pRd = bus.SNDRD_b;
            pW68 = bus.WR68k_b; pR68 = bus.RD68k_b;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk100);
        modelEdge();
        #1;
    endtask

    task automatic setIdle();
        bus.SNDWR_b  = 1'b1;
        bus.SNDRD_b  = 1'b1;
        bus.WR68k_b  = 1'b1;
        bus.RD68k_b  = 1'b1;
        bus.Dout68k  = 8'h00;
        bus.Dout6502 = 8'h00;
        SNDRST_b     = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.SNDWR_b  = v.sndWr;
        bus.SNDRD_b  = v.sndRd;
        bus.WR68k_b  = v.wr68k;
        bus.RD68k_b  = v.rd68k;
        bus.Dout68k  = v.d68;
        bus.Dout6502 = v.d65;
        tick();
    endtask

    function automatic vec_t mkVec(input logic wr, input logic srd, input logic w68,
                                   input logic r68, input logic [7:0] d68,
                                   input logic [7:0] d65, input int cnt,
                                   input logic [7:0] head, input logic [7:0] resp,
                                   input logic rfull, input logic covf, input logic rovf);
        vec_t v;
        v.sndWr = wr; v.sndRd = srd; v.wr68k = w68; v.rd68k = r68;
        v.d68 = d68; v.d65 = d65; v.expCount = cnt; v.expHead = head;
        v.expResp = resp; v.expRespFull = rfull; v.expCmdOvf = covf; v.expRespOvf = rovf;
        return v;
    endfunction

    task automatic pushCmd(input logic [7:0] d);
        bus.SNDWR_b = 1'b0; bus.Dout68k = d; tick();
        bus.SNDWR_b = 1'b1; tick();
    endtask

    task automatic popCmd();
        bus.RD68k_b = 1'b0; tick();
        bus.RD68k_b = 1'b1; tick();
    endtask

    task automatic writeResp(input logic [7:0] d);
        bus.WR68k_b = 1'b0; bus.Dout6502 = d; tick();
        bus.WR68k_b = 1'b1; tick();
    endtask

    task automatic flush();
        SNDRST_b = 1'b0; tick();
        SNDRST_b = 1'b1;
    endtask

    // Ticks until SNDNMI_b reaches lvl; a blown budget is a failed comparison.
    task automatic waitNmi(input logic lvl, input string name, output int cycles);
        cycles = 0;
        while (bus.SNDNMI_b !== lvl && cycles < 100) begin
            tick();
            cycles++;
        end
        checkOutput(name, {31'd0, bus.SNDNMI_b}, {31'd0, lvl});
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " Din68k"},      bus.Din68k,      8'h00);
        checkOutput({tag, " Din6502"},     bus.Din6502,     8'h00);
        checkOutput({tag, " SNDNMI_b"},    bus.SNDNMI_b,    1'b1);
        checkOutput({tag, " SNDINT_b"},    bus.SNDINT_b,    1'b1);
        checkOutput({tag, " ctrl_68kBUF"}, bus.ctrl_68kBUF, 1'b0);
        checkOutput({tag, " ctrl_SNDBUF"}, bus.ctrl_SNDBUF, 1'b0);
        checkOutput({tag, " cmd_count"},   bus.cmd_count,   0);
        checkOutput({tag, " cmd_ovf"},     bus.cmd_ovf,     1'b0);
        checkOutput({tag, " resp_ovf"},    bus.resp_ovf,    1'b0);
    endtask

    task automatic checkModel(input int cyc);
        string t;
        t = $sformatf("rand%0d", cyc);
        checkOutput({t, " cmd_count"},   bus.cmd_count,   mq.size());
        checkOutput({t, " Din6502"},     bus.Din6502,     (mq.size() > 0) ? mq[0] : 8'h00);
        checkOutput({t, " ctrl_68kBUF"}, bus.ctrl_68kBUF, mq.size() > 0);
        checkOutput({t, " Din68k"},      bus.Din68k,      mResp);
        checkOutput({t, " ctrl_SNDBUF"}, bus.ctrl_SNDBUF, mRespFull);
        checkOutput({t, " SNDINT_b"},    bus.SNDINT_b,    !mRespFull);
        checkOutput({t, " cmd_ovf"},     bus.cmd_ovf,     mCmdOvf);
        checkOutput({t, " resp_ovf"},    bus.resp_ovf,    mRespOvf);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c, lows;
        logic [7:0] expHeads[4];

        // Single-cycle vectors: fill to overflow, drain, then latch traffic.
        vecs.push_back(mkVec(0,1,1,1,8'h01,8'h00, 1,8'h01,8'h00,0,0,0));
        vecs.push_back(mkVec(1,1,1,1,8'h00,8'h00, 1,8'h01,8'h00,0,0,0));
        vecs.push_back(mkVec(0,1,1,1,8'h02,8'h00, 2,8'h01,8'h00,0,0,0));
        vecs.push_back(mkVec(1,1,1,1,8'h00,8'h00, 2,8'h01,8'h00,0,0,0));
        vecs.push_back(mkVec(0,1,1,1,8'h03,8'h00, 3,8'h01,8'h00,0,0,0));
        vecs.push_back(mkVec(1,1,1,1,8'h00,8'h00, 3,8'h01,8'h00,0,0,0));
        vecs.push_back(mkVec(0,1,1,1,8'h04,8'h00, 4,8'h01,8'h00,0,0,0));
        vecs.push_back(mkVec(1,1,1,1,8'h00,8'h00, 4,8'h01,8'h00,0,0,0));
        vecs.push_back(mkVec(0,1,1,1,8'h05,8'h00, 4,8'h01,8'h00,0,1,0));
        vecs.push_back(mkVec(1,1,1,1,8'h00,8'h00, 4,8'h01,8'h00,0,1,0));
        vecs.push_back(mkVec(1,1,1,0,8'h00,8'h00, 4,8'h01,8'h00,0,1,0));
        vecs.push_back(mkVec(1,1,1,1,8'h00,8'h00, 3,8'h02,8'h00,0,1,0));
        vecs.push_back(mkVec(1,1,1,0,8'h00,8'h00, 3,8'h02,8'h00,0,1,0));
        vecs.push_back(mkVec(1,1,1,1,8'h00,8'h00, 2,8'h03,8'h00,0,1,0));
        vecs.push_back(mkVec(1,1,1,0,8'h00,8'h00, 2,8'h03,8'h00,0,1,0));
        vecs.push_back(mkVec(1,1,1,1,8'h00,8'h00, 1,8'h04,8'h00,0,1,0));
        vecs.push_back(mkVec(1,1,1,0,8'h00,8'h00, 1,8'h04,8'h00,0,1,0));
        vecs.push_back(mkVec(1,1,1,1,8'h00,8'h00, 0,8'h00,8'h00,0,1,0));
        vecs.push_back(mkVec(1,1,1,0,8'h00,8'h00, 0,8'h00,8'h00,0,1,0));
        vecs.push_back(mkVec(1,1,1,1,8'h00,8'h00, 0,8'h00,8'h00,0,1,0));
        vecs.push_back(mkVec(1,1,0,1,8'h00,8'h7E, 0,8'h00,8'h7E,1,1,0));
        vecs.push_back(mkVec(1,1,1,1,8'h00,8'h00, 0,8'h00,8'h7E,1,1,0));
        vecs.push_back(mkVec(1,0,1,1,8'h00,8'h00, 0,8'h00,8'h7E,1,1,0));
        vecs.push_back(mkVec(1,1,1,1,8'h00,8'h00, 0,8'h00,8'h7E,0,1,0));
        vecs.push_back(mkVec(1,1,0,1,8'h00,8'h11, 0,8'h00,8'h11,1,1,0));
        vecs.push_back(mkVec(1,1,1,1,8'h00,8'h00, 0,8'h00,8'h11,1,1,0));
        vecs.push_back(mkVec(1,1,0,1,8'h00,8'h22, 0,8'h00,8'h22,1,1,1));
        vecs.push_back(mkVec(1,1,1,1,8'h00,8'h00, 0,8'h00,8'h22,1,1,1));

        // Power-on reset.
        setIdle();
        rst_b = 1'b0;
        modelReset();
        #12;
        checkResetValues("reset");
        rst_b = 1'b1;
        tick();

        // One command: NMI falls one cycle after the push, lasts NMI_LEN.
        bus.SNDWR_b = 1'b0; bus.Dout68k = 8'h42; tick();
        bus.SNDWR_b = 1'b1;
        checkOutput("push42 cmd_count",   bus.cmd_count,   1);
        checkOutput("push42 ctrl_68kBUF", bus.ctrl_68kBUF, 1'b1);
        checkOutput("push42 Din6502",     bus.Din6502,     8'h42);
        checkOutput("push42 nmi high",    bus.SNDNMI_b,    1'b1);
        c = -1; lows = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.SNDNMI_b == 1'b0) begin
                if (c < 0) c = i;
                lows++;
            end
        end
        checkOutput("nmi first low cycle", c,    1);
        checkOutput("nmi pulse length",    lows, NMI_LEN);
        popCmd();
        checkOutput("pop42 cmd_count", bus.cmd_count, 0);

        // Three commands, each NMI acknowledged by a pop in WAIT_ACK.
        flush();
        tick();
        pushCmd(8'hC1); pushCmd(8'hC2); pushCmd(8'hC3);
        expHeads = '{8'hC1, 8'hC2, 8'hC3, 8'h00};
        for (int n = 0; n < 3; n++) begin
            waitNmi(1'b0, $sformatf("nmi%0d start", n), c);
            waitNmi(1'b1, $sformatf("nmi%0d end", n), c);
            if (n > 0) checkOutput($sformatf("nmi%0d length", n), c, NMI_LEN);
            checkOutput($sformatf("nmi%0d head", n), bus.Din6502, expHeads[n]);
            popCmd();
            if (n < 2) begin
                waitNmi(1'b0, $sformatf("nmi%0d gap", n), c);
                checkOutput($sformatf("nmi%0d gap cycles", n), c, NMI_GAP + 1);
            end
        end
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.SNDNMI_b == 1'b0) lows++;
        end
        checkOutput("no fourth nmi", lows, 0);

        // Table-driven vectors.
        flush();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d cmd_count", i),   bus.cmd_count,   vecs[i].expCount);
            checkOutput($sformatf("vec%0d Din6502", i),     bus.Din6502,     vecs[i].expHead);
            checkOutput($sformatf("vec%0d ctrl_68kBUF", i), bus.ctrl_68kBUF, vecs[i].expCount != 0);
            checkOutput($sformatf("vec%0d Din68k", i),      bus.Din68k,      vecs[i].expResp);
            checkOutput($sformatf("vec%0d ctrl_SNDBUF", i), bus.ctrl_SNDBUF, vecs[i].expRespFull);
            checkOutput($sformatf("vec%0d SNDINT_b", i),    bus.SNDINT_b,    !vecs[i].expRespFull);
            checkOutput($sformatf("vec%0d cmd_ovf", i),     bus.cmd_ovf,     vecs[i].expCmdOvf);
            checkOutput($sformatf("vec%0d resp_ovf", i),    bus.resp_ovf,    vecs[i].expRespOvf);
        end

        // Full FIFO: push and pop in the same cycle keeps count, no overflow.
        flush();
        pushCmd(8'hA0); pushCmd(8'hA1); pushCmd(8'hA2); pushCmd(8'hA3);
        checkOutput("full cmd_count", bus.cmd_count, 4);
        bus.RD68k_b = 1'b0; tick();
        bus.SNDWR_b = 1'b0; bus.Dout68k = 8'hB4; bus.RD68k_b = 1'b1; tick();
        bus.SNDWR_b = 1'b1;
        checkOutput("samecyc cmd_count", bus.cmd_count, 4);
        checkOutput("samecyc cmd_ovf",   bus.cmd_ovf,   1'b0);
        expHeads = '{8'hA1, 8'hA2, 8'hA3, 8'hB4};
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("samecyc head%0d", i), bus.Din6502, expHeads[i]);
            popCmd();
        end
        checkOutput("samecyc drained", bus.cmd_count, 0);

        // Response read and write in the same cycle: the write wins.
        writeResp(8'h33);
        bus.SNDRD_b = 1'b0; tick();
        bus.SNDRD_b = 1'b1; bus.WR68k_b = 1'b0; bus.Dout6502 = 8'h44; tick();
        bus.WR68k_b = 1'b1;
        checkOutput("rdwr ctrl_SNDBUF", bus.ctrl_SNDBUF, 1'b1);
        checkOutput("rdwr Din68k",      bus.Din68k,      8'h44);
        checkOutput("rdwr SNDINT_b",    bus.SNDINT_b,    1'b0);
        tick();

        // Flush in the middle of a pulse with two commands queued.
        flush();
        writeResp(8'h55); writeResp(8'h56);
        pushCmd(8'hD0); pushCmd(8'hD1);
        checkOutput("midpulse nmi low",  bus.SNDNMI_b, 1'b0);
        checkOutput("midpulse resp_ovf", bus.resp_ovf, 1'b1);
        SNDRST_b = 1'b0; tick();
        SNDRST_b = 1'b1;
        checkResetValues("flush");
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.SNDNMI_b == 1'b0) lows++;
        end
        checkOutput("post-flush no nmi", lows, 0);

        // Asynchronous reset between clock edges.
        pushCmd(8'hE0); writeResp(8'hE1);
        #2;
        rst_b = 1'b0;
        modelReset();
        #1;
        checkResetValues("async");
        @(negedge clk100);
        rst_b = 1'b1;
        tick();

        // Randomized traffic against the model.
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.SNDWR_b  = ($urandom_range(0, 2) != 0);
            bus.SNDRD_b  = ($urandom_range(0, 2) != 0);
            bus.WR68k_b  = ($urandom_range(0, 2) != 0);
            bus.RD68k_b  = ($urandom_range(0, 2) != 0);
            bus.Dout68k  = 8'($urandom);
            bus.Dout6502 = 8'($urandom);
            SNDRST_b     = ($urandom_range(0, 49) != 0);
            tick();
            checkModel(cyc);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule
